ddr_read_arbiter: RTL and testbench
===================================

DDR_READ_ARBITER -- requirements
Module: ddr_read_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, the number of cache_pipeline requesters (2..8).
REQ-002 The block SHALL have parameter BURST_LEN, default `CACHE_BLOCKSIZE, the number of data beats returned per accepted request.
REQ-003 The block SHALL have the following ports, with reset i_reset (asynchronous, active-high) and clock i_clk300.
- i_clk300  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_cli_req  in  NREQ  per-client read request; held until accepted
- i_cli_raddr  in  NREQ*`MEM_ADDRBITS  client k address at [k*`MEM_ADDRBITS +: `MEM_ADDRBITS]
- o_cli_req_accepted  out  NREQ  one-cycle per-client accept pulse
- o_cli_rdata  out  `MEM_WIDTH  return data, broadcast to all clients
- o_cli_rdata_valid  out  NREQ  per-client return beat strobe
- o_ddr_raddr  out  `MEM_ADDRBITS  upstream read address
- o_ddr_rdata_req  out  1  upstream read request
- i_ddr_req_accepted  in  1  upstream accept
- i_ddr_rdata  in  `MEM_WIDTH  upstream data
- i_ddr_rdata_valid  in  1  upstream data strobe
- o_busy  out  1  high when not in S_IDLE
- o_err  out  1  sticky protocol-error flag

Function
REQ-004 The block SHALL run a three-state FSM: S_IDLE, S_REQ, S_DATA; exactly one burst is outstanding at a time.
REQ-005 In S_IDLE with any i_cli_req set, the block SHALL register owner = first requester at or after rr_ptr (wrapping from NREQ-1 to 0), latch that client's address into o_ddr_raddr, and go to S_REQ on the next edge.
REQ-006 In S_REQ the block SHALL drive o_ddr_rdata_req=1; o_ddr_rdata_req SHALL be 0 in every other state.
REQ-007 In S_REQ with i_ddr_req_accepted=1, the block SHALL assert o_cli_req_accepted[owner] combinationally in the same cycle, clear the beat counter, and go to S_DATA.
REQ-008 In S_REQ, if i_cli_req[owner] drops while i_ddr_req_accepted=0, the block SHALL return to S_IDLE without pulsing any accept and without moving rr_ptr.
REQ-009 In S_DATA, each cycle with i_ddr_rdata_valid=1 SHALL increment the beat counter; the counter is $clog2(BURST_LEN) bits wide, with a minimum of 1 bit.
REQ-010 Return path, registered with 1-cycle latency: o_cli_rdata <= i_ddr_rdata every cycle; o_cli_rdata_valid[owner] <= i_ddr_rdata_valid while in S_DATA; all other valid bits are 0.
REQ-011 On the beat with counter == BURST_LEN-1 and valid=1, the block SHALL go to S_IDLE and set rr_ptr = (owner+1) mod NREQ; no new grant is made in that same cycle.
REQ-012 The first S_IDLE cycle after a burst SHALL arbitrate normally, giving a minimum of 2 idle-to-request cycles between bursts.
REQ-013 i_ddr_rdata_valid=1 in S_IDLE or S_REQ SHALL set o_err and be discarded, with no client valid asserted; o_err clears only on reset.
REQ-014 Gaps (valid=0) within a burst SHALL be tolerated indefinitely, with no timeout.
REQ-015 o_busy SHALL equal (state != S_IDLE).
REQ-016 Requests from non-owner clients SHALL be ignored until the FSM is back in S_IDLE; o_cli_req_accepted SHALL be one-hot or zero.

Reset
REQ-017 On i_reset the block SHALL set state=S_IDLE, rr_ptr=0, owner=0, beat counter=0, o_ddr_raddr=0, o_cli_rdata=0, o_cli_rdata_valid=0 and o_err=0; o_ddr_rdata_req=0 and o_cli_req_accepted=0 follow from the state.
REQ-018 Reset asserted mid-burst SHALL abandon the burst, and beats arriving after reset release SHALL set o_err.

Verification (NREQ=4, BURST_LEN=4)
REQ-019 Single client: i_cli_req=4'b0100, addr2=0x1A0, accept at cycle 3, 4 consecutive valid beats D0..D3 -> o_ddr_raddr=0x1A0; one o_cli_req_accepted[2] pulse; o_cli_rdata_valid[2] high 4 cycles each 1 cycle after the input beat, data D0..D3; then S_IDLE with rr_ptr=3.
REQ-020 Fairness: all four clients request continuously, each re-requesting after its burst -> grant order 0,1,2,3,0; no client accepted twice before the others are served.
REQ-021 Wrap: rr_ptr=3 with i_cli_req=4'b0011 -> client 0 is granted first, then client 1.
REQ-022 Gapped burst: beats at cycles t, t+3, t+4, t+9 -> exactly 4 valid strobes to the owner; FSM leaves S_DATA only after the 4th beat.
REQ-023 Abort and error: client 1 drops its request in S_REQ before accept -> back to S_IDLE, no accept pulse, rr_ptr unchanged; a stray i_ddr_rdata_valid in S_IDLE -> o_err=1 and stays 1 until i_reset.

Source files
------------

// File: rtl/ddr_read_arbiter_if.sv
// rtl/ddr_read_arbiter_if.sv - client and DDR read-port bundle for ddr_read_arbiter
`ifndef MEM_ADDRBITS
`define MEM_ADDRBITS 32
`endif
`ifndef MEM_WIDTH
`define MEM_WIDTH 64
`endif
`ifndef CACHE_BLOCKSIZE
`define CACHE_BLOCKSIZE 4
`endif

interface ddr_read_arbiter_if #(
   parameter int NREQ = 4,
   parameter int AW   = `MEM_ADDRBITS,
   parameter int DW   = `MEM_WIDTH
);
   logic [NREQ-1:0]    i_cli_req;
   logic [NREQ*AW-1:0] i_cli_raddr;
   logic [NREQ-1:0]    o_cli_req_accepted;
   logic [DW-1:0]      o_cli_rdata;
   logic [NREQ-1:0]    o_cli_rdata_valid;
   logic [AW-1:0]      o_ddr_raddr;
   logic               o_ddr_rdata_req;
   logic               i_ddr_req_accepted;
   logic [DW-1:0]      i_ddr_rdata;
   logic               i_ddr_rdata_valid;

   // Arbiter side
   modport slave (
      input  i_cli_req, i_cli_raddr, i_ddr_req_accepted, i_ddr_rdata, i_ddr_rdata_valid,
      output o_cli_req_accepted, o_cli_rdata, o_cli_rdata_valid, o_ddr_raddr, o_ddr_rdata_req
   );

   // Clients plus DDR controller side
   modport master (
      output i_cli_req, i_cli_raddr, i_ddr_req_accepted, i_ddr_rdata, i_ddr_rdata_valid,
      input  o_cli_req_accepted, o_cli_rdata, o_cli_rdata_valid, o_ddr_raddr, o_ddr_rdata_req
   );
endinterface

// File: rtl/ddr_read_arbiter.sv
// rtl/ddr_read_arbiter.sv - round-robin arbiter sharing one DDR read port among cache clients
`ifndef MEM_ADDRBITS
`define MEM_ADDRBITS 32
`endif
`ifndef MEM_WIDTH
`define MEM_WIDTH 64
`endif
`ifndef CACHE_BLOCKSIZE
`define CACHE_BLOCKSIZE 4
`endif

module ddr_read_arbiter #(
   parameter int NREQ      = 4,
   parameter int BURST_LEN = `CACHE_BLOCKSIZE
) (
   input  logic               i_clk300,
   input  logic               i_reset,
   ddr_read_arbiter_if.slave  bus,
   output logic               o_busy,
   output logic               o_err
);
   localparam int AW = `MEM_ADDRBITS;
   localparam int DW = `MEM_WIDTH;
   localparam int PW = $clog2(NREQ);
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   logic [DW-1:0]   rdata_q;
   logic [NREQ-1:0] rvalid_q, rvalid_d;
   logic            err_q, err_d;
   logic [NREQ-1:0] accept;
   logic [PW-1:0]   grant, cand;
   logic            grant_vld;

   // Scan from the farthest candidate back so the one nearest rr_ptr wins.
   always_comb begin
      grant     = rr_ptr_q;
      grant_vld = 1'b0;
      cand      = rr_ptr_q;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = PW'((int'(rr_ptr_q) + k) % NREQ);
         if (bus.i_cli_req[cand]) begin
            grant     = cand;
            grant_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      beat_d   = beat_q;
      raddr_d  = raddr_q;
      rvalid_d = '0;
      err_d    = err_q;
      accept   = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_ddr_rdata_valid) err_d = 1'b1;
            if (grant_vld) begin
               owner_d = grant;
               raddr_d = bus.i_cli_raddr[int'(grant)*AW +: AW];
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.i_ddr_rdata_valid) err_d = 1'b1;
            if (bus.i_ddr_req_accepted) begin
               accept[owner_q] = 1'b1;
               beat_d          = '0;
               state_d         = S_DATA;
            end else if (!bus.i_cli_req[owner_q]) begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (bus.i_ddr_rdata_valid) begin
               rvalid_d[owner_q] = 1'b1;
               beat_d            = beat_q + 1'b1;
               if (beat_q == BW'(BURST_LEN - 1)) begin
                  state_d  = S_IDLE;
                  rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk300 or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         beat_q   <= '0;
         raddr_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         beat_q   <= beat_d;
         raddr_q  <= raddr_d;
         rdata_q  <= bus.i_ddr_rdata;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   assign bus.o_cli_req_accepted = accept;
   assign bus.o_cli_rdata        = rdata_q;
   assign bus.o_cli_rdata_valid  = rvalid_q;
   assign bus.o_ddr_raddr        = raddr_q;
   assign bus.o_ddr_rdata_req    = (state_q == S_REQ);
   assign o_busy                 = (state_q != S_IDLE);
   assign o_err                  = err_q;
endmodule

// File: tb/tb_ddr_read_arbiter.sv
// tb/tb_ddr_read_arbiter.sv - directed self-checking bench for ddr_read_arbiter (NREQ=4, BURST_LEN=4)
`ifndef MEM_ADDRBITS
`define MEM_ADDRBITS 32
`endif
`ifndef MEM_WIDTH
`define MEM_WIDTH 64
`endif
`ifndef CACHE_BLOCKSIZE
`define CACHE_BLOCKSIZE 4
`endif

module tb_ddr_read_arbiter;
   logic i_clk300 = 1'b0;
   logic i_reset;
   logic o_busy;
   logic o_err;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] addrs [4];
   logic [3:0]  pat;

   ddr_read_arbiter_if #(.NREQ(4)) bus ();

   ddr_read_arbiter #(.NREQ(4), .BURST_LEN(4)) dut (
      .i_clk300 (i_clk300),
      .i_reset  (i_reset),
      .bus      (bus),
      .o_busy   (o_busy),
      .o_err    (o_err)
   );

   always #5 i_clk300 = ~i_clk300;

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge i_clk300);
      #2;
   endtask

   // Idle with requests pending -> request phase -> accepted in the next cycle.
   task automatic grant(input logic [3:0] m, input logic [31:0] a, input string tag);
      step();
      chk({tag, ".rdata_req"}, 64'(bus.o_ddr_rdata_req), 64'd1);
      chk({tag, ".raddr"}, 64'(bus.o_ddr_raddr), 64'(a));
      chk({tag, ".busy"}, 64'(o_busy), 64'd1);
      chk({tag, ".no_valid"}, 64'(bus.o_cli_rdata_valid), 64'd0);
      chk({tag, ".no_acc_yet"}, 64'(bus.o_cli_req_accepted), 64'd0);
      bus.i_ddr_req_accepted = 1'b1;
      #1;
      chk({tag, ".acc"}, 64'(bus.o_cli_req_accepted), 64'(m));
      step();
      bus.i_ddr_req_accepted = 1'b0;
      #1;
      chk({tag, ".acc_off"}, 64'(bus.o_cli_req_accepted), 64'd0);
      chk({tag, ".req_off"}, 64'(bus.o_ddr_rdata_req), 64'd0);
   endtask

   task automatic burst(input logic [3:0] m, input logic [63:0] base, input string tag);
      for (int i = 0; i < 4; i++) begin
         bus.i_ddr_rdata       = base + 64'(i);
         bus.i_ddr_rdata_valid = 1'b1;
         step();
         chk($sformatf("%s.valid%0d", tag, i), 64'(bus.o_cli_rdata_valid), 64'(m));
         chk($sformatf("%s.data%0d", tag, i), bus.o_cli_rdata, base + 64'(i));
      end
      bus.i_ddr_rdata_valid = 1'b0;
      chk({tag, ".done_idle"}, 64'(o_busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      addrs[0] = 32'h100;
      addrs[1] = 32'h140;
      addrs[2] = 32'h1A0;
      addrs[3] = 32'h3C0;
      i_reset                = 1'b1;
      bus.i_cli_req          = '0;
      bus.i_cli_raddr        = {addrs[3], addrs[2], addrs[1], addrs[0]};
      bus.i_ddr_req_accepted = 1'b0;
      bus.i_ddr_rdata        = '0;
      bus.i_ddr_rdata_valid  = 1'b0;

      // Reset state
      step(); step(); step();
      chk("rst.busy", 64'(o_busy), 64'd0);
      chk("rst.err", 64'(o_err), 64'd0);
      chk("rst.rdata_req", 64'(bus.o_ddr_rdata_req), 64'd0);
      chk("rst.acc", 64'(bus.o_cli_req_accepted), 64'd0);
      chk("rst.valid", 64'(bus.o_cli_rdata_valid), 64'd0);
      chk("rst.raddr", 64'(bus.o_ddr_raddr), 64'd0);
      chk("rst.rdata", bus.o_cli_rdata, 64'd0);
      i_reset = 1'b0;
      step();
      chk("post_rst.busy", 64'(o_busy), 64'd0);

      // Single client 2; one cycle left unaccepted in the request phase
      bus.i_cli_req = 4'b0100;
      step();
      chk("t1.wait_req", 64'(bus.o_ddr_rdata_req), 64'd1);
      chk("t1.wait_raddr", 64'(bus.o_ddr_raddr), 64'h1A0);
      grant(4'b0100, 32'h1A0, "t1");
      bus.i_cli_req = 4'b0000;
      burst(4'b0100, 64'hD0, "t1");
      step();
      chk("t1.idle_valid", 64'(bus.o_cli_rdata_valid), 64'd0);
      chk("t1.idle_busy", 64'(o_busy), 64'd0);

      // Wrap from rr_ptr=3: client 0 before client 1
      bus.i_cli_req = 4'b0011;
      grant(4'b0001, 32'h100, "wrap0");
      bus.i_cli_req = 4'b0010;
      burst(4'b0001, 64'hA0, "wrap0");
      grant(4'b0010, 32'h140, "wrap1");
      bus.i_cli_req = 4'b0000;
      burst(4'b0010, 64'hB0, "wrap1");
      step();

      // Gapped burst on client 3: beats at t, t+3, t+4, t+9
      bus.i_cli_req = 4'b1000;
      grant(4'b1000, 32'h3C0, "gap");
      bus.i_cli_req = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         bus.i_ddr_rdata_valid = (i == 0 || i == 3 || i == 4 || i == 9);
         bus.i_ddr_rdata       = 64'hC0 + 64'(i);
         pat = bus.i_ddr_rdata_valid ? 4'b1000 : 4'b0000;
         step();
         chk($sformatf("gap.valid%0d", i), 64'(bus.o_cli_rdata_valid), 64'(pat));
         chk($sformatf("gap.busy%0d", i), 64'(o_busy), (i < 9) ? 64'd1 : 64'd0);
      end
      bus.i_ddr_rdata_valid = 1'b0;
      chk("gap.last_data", bus.o_cli_rdata, 64'hC9);
      step();

      // Abort: client 1 drops before accept; rr_ptr must stay at 0
      bus.i_cli_req = 4'b0010;
      step();
      chk("abort.req", 64'(bus.o_ddr_rdata_req), 64'd1);
      chk("abort.raddr", 64'(bus.o_ddr_raddr), 64'h140);
      bus.i_cli_req = 4'b0000;
      #1;
      chk("abort.no_acc", 64'(bus.o_cli_req_accepted), 64'd0);
      step();
      chk("abort.idle", 64'(o_busy), 64'd0);
      chk("abort.req_off", 64'(bus.o_ddr_rdata_req), 64'd0);
      bus.i_cli_req = 4'b0101;
      grant(4'b0001, 32'h100, "abort.next");
      bus.i_cli_req = 4'b0000;
      burst(4'b0001, 64'hE0, "abort.next");
      step();

      // Stray beat in idle sets the sticky error
      bus.i_ddr_rdata       = 64'h55;
      bus.i_ddr_rdata_valid = 1'b1;
      step();
      chk("stray.err", 64'(o_err), 64'd1);
      chk("stray.no_valid", 64'(bus.o_cli_rdata_valid), 64'd0);
      bus.i_ddr_rdata_valid = 1'b0;
      step(); step();
      chk("stray.sticky", 64'(o_err), 64'd1);
      bus.i_cli_req = 4'b0100;
      grant(4'b0100, 32'h1A0, "stray.next");
      bus.i_cli_req = 4'b0000;
      burst(4'b0100, 64'hF0, "stray.next");
      chk("stray.sticky2", 64'(o_err), 64'd1);
      step();

      // Reset mid-burst, then a late beat is an error
      bus.i_cli_req = 4'b0010;
      grant(4'b0010, 32'h140, "midrst");
      bus.i_cli_req         = 4'b0000;
      bus.i_ddr_rdata       = 64'h77;
      bus.i_ddr_rdata_valid = 1'b1;
      step();
      chk("midrst.beat", 64'(bus.o_cli_rdata_valid), 64'b0010);
      i_reset = 1'b1;
      #1;
      chk("midrst.busy", 64'(o_busy), 64'd0);
      chk("midrst.err", 64'(o_err), 64'd0);
      chk("midrst.valid", 64'(bus.o_cli_rdata_valid), 64'd0);
      chk("midrst.raddr", 64'(bus.o_ddr_raddr), 64'd0);
      chk("midrst.rdata", bus.o_cli_rdata, 64'd0);
      bus.i_ddr_rdata_valid = 1'b0;
      step();
      i_reset               = 1'b0;
      bus.i_ddr_rdata_valid = 1'b1;
      step();
      chk("late.err", 64'(o_err), 64'd1);
      chk("late.no_valid", 64'(bus.o_cli_rdata_valid), 64'd0);
      chk("late.busy", 64'(o_busy), 64'd0);
      bus.i_ddr_rdata_valid = 1'b0;
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      chk("rst2.err", 64'(o_err), 64'd0);

      // Fairness from rr_ptr=0 with every client requesting continuously
      bus.i_cli_req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         grant(4'(1 << (n % 4)), addrs[n % 4], $sformatf("fair%0d", n));
         burst(4'(1 << (n % 4)), 64'h1000 + 64'(n * 16), $sformatf("fair%0d", n));
      end
      bus.i_cli_req = 4'b0000;
      step();
      chk("fair.idle", 64'(o_busy), 64'd0);
      chk("fair.err", 64'(o_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
